// File: rtl/mult_arbiter.sv
// mult_arbiter
// Round-robin arbiter and sequencer that shares one sequential multiplier
// among N_REQ requesters. Only one operand pair is in flight at a time. A
// watchdog aborts a transaction whose multiplier never reports completion.
//
// Ports
//   clk_in, rst_in      clock (rising edge), asynchronous active-high reset
//   req_valid/x/y       per-requester operand-valid and packed operands
//   req_ready           one-hot accept strobe (combinational, IDLE only)
//   mul_start/x/y       start pulse and latched operands to the multiplier
//   mul_done/product    completion pulse and result from the multiplier
//   rsp_valid           one-hot, one-cycle response strobe
//   rsp_product/err     result (0 with err=1 on timeout), held until next response
//   busy, grant_id      not-idle flag, index of current/last grant
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_x,
  input  logic [N_REQ*WIDTH-1:0]   req_y,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_x,
  output logic [WIDTH-1:0]         mul_y,
  input  logic                     mul_done,
  input  logic [2*WIDTH-1:0]       mul_product,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [WIDTH-1:0]   mul_x_q, mul_x_d;
  logic [WIDTH-1:0]   mul_y_q, mul_y_d;
  logic               mul_start_q, mul_start_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         cnt_inc;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;
  logic               rsp_err_q, rsp_err_d;
  logic               busy_q, busy_d;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  logic          found;
  logic [GW-1:0] win;
  logic [GW-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned; otherwise synthesis infers a latch.
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = GW'((int'(rr_ptr_q) + i) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    mul_x_d       = mul_x_q;
    mul_y_d       = mul_y_q;
    mul_start_d   = 1'b0;
    cnt_d         = cnt_q;
    rsp_valid_d   = '0;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    req_ready     = '0;

    case (state_q)
      S_IDLE: begin
        // Held low during reset so the accept strobe matches the reset state.
        if (found && !rst_in) begin
          req_ready[win] = 1'b1;
          mul_x_d        = req_x[int'(win)*WIDTH +: WIDTH];
          mul_y_d        = req_y[int'(win)*WIDTH +: WIDTH];
          grant_id_d     = win;
          mul_start_d    = 1'b1;   // registered: high during ISSUE
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion has priority over the watchdog in the same cycle.
        if (mul_done) begin
          rsp_product_d           = mul_product;
          rsp_err_d               = 1'b0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == 8'(TIMEOUT)) begin
            rsp_product_d           = '0;
            rsp_err_d               = 1'b1;
            rsp_valid_d[grant_id_q] = 1'b1;
            state_d                 = S_RESP;
          end
        end
      end
      S_RESP: begin
        rr_ptr_d = (grant_id_q == GW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      mul_x_q       <= '0;
      mul_y_q       <= '0;
      mul_start_q   <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      mul_x_q       <= mul_x_d;
      mul_y_q       <= mul_y_d;
      mul_start_q   <= mul_start_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign mul_start   = mul_start_q;
  assign mul_x       = mul_x_q;
  assign mul_y       = mul_y_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: table-driven transactions with a
// bench-side multiplier model, plus hand-written reset sequences.
module tb_mult_arbiter;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;
  localparam int GW      = 2;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_x;
  logic [N_REQ*WIDTH-1:0] req_y;
  logic [N_REQ-1:0]       req_ready;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_x;
  logic [WIDTH-1:0]       mul_y;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_product;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   rsp_err;
  logic                   busy;
  logic [GW-1:0]          grant_id;

  mult_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
    .mul_done(mul_done), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk_in = ~clk_in;

  // Fixed operands per requester: x = 3,5,13,15 and y = 6,9,11,15.
  logic [WIDTH-1:0] xs [N_REQ];
  logic [WIDTH-1:0] ys [N_REQ];

  // lat = cycles from mul_start to mul_done (0 = multiplier never answers).
  // stray = inject a bogus mul_done during ISSUE, which must be ignored.
  typedef struct {
    logic [N_REQ-1:0]   valid;
    int                 lat;
    logic               stray;
    int                 grant;
    logic [2*WIDTH-1:0] prod;
    logic               err;
  } vec_t;

  vec_t vecs [15];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int k, input vec_t v);
    int waited;
    bit got;
    int n;
    @(negedge clk_in);
    req_valid = v.valid;
    waited = 0;
    got = 0;
    #1;
    while (!got && waited < 8) begin
      if (req_ready != '0) got = 1;
      else begin
        @(negedge clk_in);
        #1;
        waited++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL v%0d ready_timeout: got no req_ready expected %0h", k, 32'd1 << v.grant);
      return;
    end
    check($sformatf("v%0d ready", k), 32'(req_ready), 32'd1 << v.grant);
    check($sformatf("v%0d ready_lat", k), waited, 0);

    // Cycle A+1: ISSUE
    @(negedge clk_in);
    if (v.stray) begin
      mul_done    = 1'b1;
      mul_product = 8'hAA;
    end
    #1;
    check($sformatf("v%0d mul_start", k), 32'(mul_start), 1);
    check($sformatf("v%0d mul_x", k), 32'(mul_x), 32'(xs[v.grant]));
    check($sformatf("v%0d mul_y", k), 32'(mul_y), 32'(ys[v.grant]));
    check($sformatf("v%0d grant_id", k), 32'(grant_id), v.grant);
    check($sformatf("v%0d busy_issue", k), 32'(busy), 1);
    check($sformatf("v%0d ready_off", k), 32'(req_ready), 0);

    // Cycles A+2 .. A+1+n: WAIT, multiplier model answers at A+1+lat.
    n = (v.lat == 0) ? TIMEOUT : v.lat;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk_in);
      mul_done    = 1'b0;
      mul_product = '0;
      if (j == v.lat) begin
        mul_done    = 1'b1;
        mul_product = v.prod;
      end
      #1;
      if (j == 1) check($sformatf("v%0d start_pulse", k), 32'(mul_start), 0);
      if (j == n) begin
        check($sformatf("v%0d rsp_early", k), 32'(rsp_valid), 0);
        check($sformatf("v%0d mul_x_held", k), 32'(mul_x), 32'(xs[v.grant]));
      end
    end

    // Cycle A+2+lat (or A+2+TIMEOUT): RESP
    @(negedge clk_in);
    mul_done    = 1'b0;
    mul_product = '0;
    #1;
    check($sformatf("v%0d rsp_valid", k), 32'(rsp_valid), 32'd1 << v.grant);
    check($sformatf("v%0d rsp_product", k), 32'(rsp_product), 32'(v.prod));
    check($sformatf("v%0d rsp_err", k), 32'(rsp_err), 32'(v.err));
    check($sformatf("v%0d busy_resp", k), 32'(busy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit saw_rsp;
    bit saw_busy;
    vec_t post;

    xs[0] = 4'd3;  ys[0] = 4'd6;
    xs[1] = 4'd5;  ys[1] = 4'd9;
    xs[2] = 4'd13; ys[2] = 4'd11;
    xs[3] = 4'd15; ys[3] = 4'd15;

    //            valid    lat stray grant prod     err
    vecs[0]  = '{4'b1111, 1,  1'b0, 0, 8'd18,  1'b0}; // fairness 0,1,2,3,0
    vecs[1]  = '{4'b1111, 2,  1'b1, 1, 8'd45,  1'b0}; // stray done in ISSUE
    vecs[2]  = '{4'b1111, 3,  1'b0, 2, 8'd143, 1'b0};
    vecs[3]  = '{4'b1111, 1,  1'b0, 3, 8'd225, 1'b0};
    vecs[4]  = '{4'b1111, 2,  1'b0, 0, 8'd18,  1'b0};
    vecs[5]  = '{4'b0100, 4,  1'b0, 2, 8'd143, 1'b0}; // single request 13*11
    vecs[6]  = '{4'b1000, 1,  1'b0, 3, 8'd225, 1'b0};
    vecs[7]  = '{4'b0011, 1,  1'b0, 0, 8'd18,  1'b0}; // after grant 3 -> 0
    vecs[8]  = '{4'b0011, 1,  1'b0, 1, 8'd45,  1'b0}; // then 1
    vecs[9]  = '{4'b0011, 1,  1'b0, 0, 8'd18,  1'b0}; // rr_ptr=2 wraps to 0
    vecs[10] = '{4'b0010, 0,  1'b0, 1, 8'd0,   1'b1}; // timeout
    vecs[11] = '{4'b1000, 2,  1'b0, 3, 8'd225, 1'b0}; // normal after timeout
    vecs[12] = '{4'b1000, 15, 1'b0, 3, 8'd225, 1'b0}; // done on timeout cycle
    vecs[13] = '{4'b0101, 1,  1'b0, 0, 8'd18,  1'b0};
    vecs[14] = '{4'b0101, 1,  1'b0, 2, 8'd143, 1'b0}; // leaves rr_ptr=3

    rst_in      = 1'b1;
    req_valid   = '0;
    req_x       = {xs[3], xs[2], xs[1], xs[0]};
    req_y       = {ys[3], ys[2], ys[1], ys[0]};
    mul_done    = 1'b0;
    mul_product = '0;

    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst rsp_valid", 32'(rsp_valid), 0);
    check("rst mul_start", 32'(mul_start), 0);
    check("rst mul_x", 32'(mul_x), 0);
    check("rst mul_y", 32'(mul_y), 0);
    check("rst grant_id", 32'(grant_id), 0);
    check("rst rsp_product", 32'(rsp_product), 0);
    check("rst rsp_err", 32'(rsp_err), 0);
    check("rst req_ready", 32'(req_ready), 0);

    @(negedge clk_in);
    rst_in = 1'b0;

    for (int k = 0; k < 15; k++) run_txn(k, vecs[k]);

    // Reset in the middle of WAIT: grant to 1 (rr_ptr=3), abort, then stale done.
    @(negedge clk_in);
    req_valid = 4'b0010;
    #1;
    check("mid ready", 32'(req_ready), 32'b0010);
    @(negedge clk_in);           // ISSUE
    @(negedge clk_in);           // WAIT
    @(negedge clk_in);           // WAIT
    rst_in = 1'b1;
    #1;
    check("mid busy", 32'(busy), 0);
    check("mid grant_id", 32'(grant_id), 0);
    check("mid mul_x", 32'(mul_x), 0);
    check("mid rsp_product", 32'(rsp_product), 0);
    check("mid req_ready", 32'(req_ready), 0);
    req_valid = '0;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    mul_done    = 1'b1;
    mul_product = 8'h5A;
    @(negedge clk_in);
    mul_done    = 1'b0;
    mul_product = '0;
    saw_rsp  = 1'b0;
    saw_busy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      if (rsp_valid != '0) saw_rsp = 1'b1;
      if (busy) saw_busy = 1'b1;
      @(negedge clk_in);
    end
    check("mid no_rsp", 32'(saw_rsp), 0);
    check("mid idle", 32'(saw_busy), 0);

    // rr_ptr is back at 0, so all-valid grants requester 0 first.
    post = '{4'b1111, 2, 1'b0, 0, 8'd18, 1'b0};
    run_txn(15, post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
